pcr_timebase: RTL and testbench

Parametrised 27 MHz PCR timebase for the TS re-multiplexing path. It keeps a running PCR counter (33-bit base plus 9-bit extension, extension modulus 300), advanced either by rising edges of an asynchronous external 27 MHz clock or by an internal NCO clocked from the main clock. It adds three things the PCR correction logic needs: preset/load, an atomic snapshot handshake, and loss-of-reference detection. It sits beside the PCR correction datapath, which samples it through the snapshot port.

---
 rtl/pcr_pkg.sv | 24 ++
 rtl/pcr_edge_sync.sv | 25 ++
 rtl/pcr_timebase.sv | 77 +++++++
 tb/tb_pcr_timebase.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcr_pkg.sv
// Shared PCR widths, counter value type and the base/extension advance rule.
package pcr_pkg;
  localparam int PCR_BASE_W      = 33;
  localparam int PCR_EXT_W       = 9;
  localparam int PCR_EXT_MOD_DEF = 300;

  typedef struct packed {
    logic [PCR_BASE_W-1:0] base;
    logic [PCR_EXT_W-1:0]  ext;
  } pcr_val_t;

  // Out-of-range extensions also roll over so a bad value can never stick.
  function automatic pcr_val_t pcr_advance(input pcr_val_t v, input logic [PCR_EXT_W-1:0] ext_last);
    pcr_val_t r;
    r = v;
    if (v.ext >= ext_last) begin
      r.ext  = '0;
      r.base = v.base + PCR_BASE_W'(1);
    end else begin
      r.ext  = v.ext + PCR_EXT_W'(1);
    end
    return r;
  endfunction
endpackage

// File: rtl/pcr_edge_sync.sv
// clk_27m synchroniser plus rising-edge pulse, gated until the chain has refilled after reset.
module pcr_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_main_a,
  input  logic rst_gen,
  input  logic clk_27m,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_pipe;

  always_ff @(posedge clk_main_a or posedge rst_gen) begin
    if (rst_gen) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_27m};
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // A high reference at release fills the chain with 1s; no edge is reported until then.
  assign rise = vld_pipe[SYNC_STAGES] & sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/pcr_timebase.sv
// 27 MHz PCR timebase: base/extension counter ticked by clk_27m edges or an NCO,
// with preset, tear-free snapshot and loss-of-reference detection.
module pcr_timebase
  import pcr_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EXT_MOD     = PCR_EXT_MOD_DEF,
  parameter int NCO_W       = 32,
  parameter int LOSS_CYCLES = 64
) (
  input  logic                  clk_main_a,
  input  logic                  rst_gen,
  input  logic                  clk_27m,
  input  logic                  src_sel,
  input  logic [NCO_W-1:0]      nco_inc,
  input  logic                  load_req,
  input  logic [PCR_BASE_W-1:0] load_base,
  input  logic [PCR_EXT_W-1:0]  load_ext,
  input  logic                  snap_req,
  output logic                  snap_valid,
  output logic [PCR_BASE_W-1:0] snap_base,
  output logic [PCR_EXT_W-1:0]  snap_ext,
  output logic [PCR_BASE_W-1:0] pcr_base_cnt,
  output logic [PCR_EXT_W-1:0]  pcr_ext_cnt,
  output logic                  tick,
  output logic                  clk_27m_lost
);
  localparam logic [PCR_EXT_W-1:0] EXT_LAST  = PCR_EXT_W'(EXT_MOD - 1);
  localparam logic [PCR_EXT_W-1:0] EXT_LIMIT = PCR_EXT_W'(EXT_MOD);
  localparam int                   LOSS_W    = $clog2(LOSS_CYCLES + 1);
  localparam logic [LOSS_W-1:0]    LOSS_MAX  = LOSS_W'(LOSS_CYCLES);

  logic              edge_27m;
  logic [NCO_W-1:0]  acc, acc_sum;
  logic              nco_carry, tick_src;
  logic [LOSS_W-1:0] loss_cnt;
  pcr_val_t          cnt, snap, load_val;

  pcr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clk_main_a (clk_main_a),
    .rst_gen    (rst_gen),
    .clk_27m    (clk_27m),
    .rise       (edge_27m)
  );

  assign {nco_carry, acc_sum} = {1'b0, acc} + {1'b0, nco_inc};
  assign tick_src      = src_sel ? nco_carry : edge_27m;
  assign load_val.base = load_base;
  assign load_val.ext  = (load_ext >= EXT_LIMIT) ? '0 : load_ext;

  always_ff @(posedge clk_main_a or posedge rst_gen) begin
    if (rst_gen) begin
      acc        <= '0;
      cnt        <= '0;
      snap       <= '0;
      snap_valid <= 1'b0;
      tick       <= 1'b0;
      loss_cnt   <= '0;
    end else begin
      acc  <= src_sel ? acc_sum : '0;
      tick <= tick_src & ~load_req;
      if (load_req)      cnt <= load_val;
      else if (tick_src) cnt <= pcr_advance(cnt, EXT_LAST);
      // Snapshot takes the pre-update value so base and ext always belong together.
      snap_valid <= snap_req;
      if (snap_req) snap <= cnt;
      if (src_sel || edge_27m)     loss_cnt <= '0;
      else if (loss_cnt != LOSS_MAX) loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign pcr_base_cnt = cnt.base;
  assign pcr_ext_cnt  = cnt.ext;
  assign snap_base    = snap.base;
  assign snap_ext     = snap.ext;
  assign clk_27m_lost = (loss_cnt >= LOSS_MAX);
endmodule

// File: tb/tb_pcr_timebase.sv
// Scenario bench for pcr_timebase: reference edges, wraps, load, snapshot, NCO, loss, reset.
module tb_pcr_timebase;
  import pcr_pkg::*;

  logic                  clk_main_a, rst_gen, clk_27m, src_sel;
  logic [31:0]           nco_inc;
  logic                  load_req, snap_req;
  logic [PCR_BASE_W-1:0] load_base;
  logic [PCR_EXT_W-1:0]  load_ext;
  logic                  snap_valid, tick, clk_27m_lost;
  logic [PCR_BASE_W-1:0] snap_base, pcr_base_cnt;
  logic [PCR_EXT_W-1:0]  snap_ext, pcr_ext_cnt;

  typedef struct packed {
    pcr_val_t v;
    logic     t;
  } exp_t;

  int       n_cmp = 0;
  int       n_mis = 0;
  pcr_val_t m;
  exp_t     exp_q[$];
  pcr_val_t snap_q[$];

  pcr_timebase #(.SYNC_STAGES(2), .EXT_MOD(300), .NCO_W(32), .LOSS_CYCLES(64)) dut (
    .clk_main_a(clk_main_a), .rst_gen(rst_gen), .clk_27m(clk_27m), .src_sel(src_sel),
    .nco_inc(nco_inc), .load_req(load_req), .load_base(load_base), .load_ext(load_ext),
    .snap_req(snap_req), .snap_valid(snap_valid), .snap_base(snap_base), .snap_ext(snap_ext),
    .pcr_base_cnt(pcr_base_cnt), .pcr_ext_cnt(pcr_ext_cnt), .tick(tick),
    .clk_27m_lost(clk_27m_lost)
  );

  initial begin
    clk_main_a = 1'b0;
    forever #5 clk_main_a = ~clk_main_a;
  end

  function automatic pcr_val_t model_adv(input pcr_val_t v);
    pcr_val_t r;
    r = v;
    if (v.ext == 9'd299) begin
      r.ext  = 9'd0;
      r.base = v.base + 33'd1;
    end else begin
      r.ext = v.ext + 9'd1;
    end
    return r;
  endfunction

  // One clk_27m pulse; expects exactly one tick carrying the next model value.
  task automatic edge_expect(input string nm);
    exp_t e;
    int   nt;
    nt = 0;
    m  = model_adv(m);
    e.v = m; e.t = 1'b1;
    exp_q.push_back(e);
    clk_27m = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_main_a);
      if (i == 5) clk_27m = 1'b0;
      if (tick) begin
        nt++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({pcr_base_cnt, pcr_ext_cnt} !== e.v) begin
            n_mis++;
            $display("FAIL %s value: got %0h/%0d exp %0h/%0d", nm, pcr_base_cnt, pcr_ext_cnt, e.v.base, e.v.ext);
          end
        end
      end
    end
    exp_q.delete();
    n_cmp++;
    if (nt !== 1) begin
      n_mis++;
      $display("FAIL %s ticks: got %0d exp 1", nm, nt);
    end
  endtask

  task automatic do_load(input logic [32:0] b, input logic [8:0] e);
    load_req = 1'b1; load_base = b; load_ext = e;
    @(negedge clk_main_a);
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_gen = 1'b1; clk_27m = 1'b0; src_sel = 1'b0; nco_inc = '0;
    load_req = 1'b0; load_base = '0; load_ext = '0; snap_req = 1'b0;
    m = '0;
    repeat (3) @(negedge clk_main_a);
    n_cmp++;
    if ({pcr_base_cnt, pcr_ext_cnt, tick} !== '0) begin
      n_mis++;
      $display("FAIL reset_cnt: got %0h/%0d t%0b exp 0/0 t0", pcr_base_cnt, pcr_ext_cnt, tick);
    end
    n_cmp++;
    if ({snap_base, snap_ext, snap_valid, clk_27m_lost} !== '0) begin
      n_mis++;
      $display("FAIL reset_snap: got %0h/%0d v%0b l%0b exp all 0", snap_base, snap_ext, snap_valid, clk_27m_lost);
    end
    rst_gen = 1'b0;
    repeat (5) @(negedge clk_main_a);
  endtask

  task automatic test_ext_wrap();
    do_load(33'd5, 9'd298);
    m.base = 33'd5; m.ext = 9'd298;
    n_cmp++;
    if ({pcr_base_cnt, pcr_ext_cnt} !== m) begin
      n_mis++;
      $display("FAIL load_5_298: got %0d/%0d exp 5/298", pcr_base_cnt, pcr_ext_cnt);
    end
    edge_expect("ext_wrap_299");
    edge_expect("ext_wrap_0");
  endtask

  task automatic test_base_wrap();
    do_load(33'h1_FFFF_FFFF, 9'd299);
    m.base = 33'h1_FFFF_FFFF; m.ext = 9'd299;
    edge_expect("base_wrap");
    n_cmp++;
    if ({pcr_base_cnt, pcr_ext_cnt} !== '0) begin
      n_mis++;
      $display("FAIL base_wrap_zero: got %0h/%0d exp 0/0", pcr_base_cnt, pcr_ext_cnt);
    end
  endtask

  task automatic test_load_collision();
    // Load held across the whole window in which the edge can be detected.
    clk_27m = 1'b1;
    load_req = 1'b1; load_base = 33'd100; load_ext = 9'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_main_a);
      n_cmp++;
      if (pcr_base_cnt !== 33'd100 || pcr_ext_cnt !== 9'd7 || tick !== 1'b0) begin
        n_mis++;
        $display("FAIL load_collide[%0d]: got %0d/%0d t%0b exp 100/7 t0", i, pcr_base_cnt, pcr_ext_cnt, tick);
      end
    end
    load_req = 1'b0; clk_27m = 1'b0;
    repeat (4) @(negedge clk_main_a);
    n_cmp++;
    if (pcr_base_cnt !== 33'd100 || pcr_ext_cnt !== 9'd7) begin
      n_mis++;
      $display("FAIL load_collide_hold: got %0d/%0d exp 100/7", pcr_base_cnt, pcr_ext_cnt);
    end
    do_load(33'd55, 9'd300);
    n_cmp++;
    if (pcr_base_cnt !== 33'd55 || pcr_ext_cnt !== 9'd0) begin
      n_mis++;
      $display("FAIL load_ext_clamp: got %0d/%0d exp 55/0", pcr_base_cnt, pcr_ext_cnt);
    end
  endtask

  task automatic test_snapshot();
    do_load(33'd10, 9'd299);
    clk_27m = 1'b1;
    @(negedge clk_main_a);
    snap_req = 1'b1;
    @(negedge clk_main_a);
    snap_req = 1'b0;
    n_cmp++;
    if (tick !== 1'b1 || pcr_base_cnt !== 33'd11 || pcr_ext_cnt !== 9'd0) begin
      n_mis++;
      $display("FAIL snap_live: got %0d/%0d t%0b exp 11/0 t1", pcr_base_cnt, pcr_ext_cnt, tick);
    end
    n_cmp++;
    if (snap_valid !== 1'b1 || snap_base !== 33'd10 || snap_ext !== 9'd299) begin
      n_mis++;
      $display("FAIL snap_capture: got v%0b %0d/%0d exp v1 10/299", snap_valid, snap_base, snap_ext);
    end
    @(negedge clk_main_a);
    n_cmp++;
    if (snap_valid !== 1'b0 || snap_base !== 33'd10 || snap_ext !== 9'd299) begin
      n_mis++;
      $display("FAIL snap_hold: got v%0b %0d/%0d exp v0 10/299", snap_valid, snap_base, snap_ext);
    end
    clk_27m = 1'b0;
    repeat (4) @(negedge clk_main_a);
    m.base = 33'd11; m.ext = 9'd0;
  endtask

  task automatic test_async_reset();
    #2 rst_gen = 1'b1;
    #1;
    n_cmp++;
    if ({pcr_base_cnt, pcr_ext_cnt, snap_base, snap_ext, snap_valid, tick, clk_27m_lost} !== '0) begin
      n_mis++;
      $display("FAIL async_reset: got %0h/%0d snap %0h/%0d exp all 0", pcr_base_cnt, pcr_ext_cnt, snap_base, snap_ext);
    end
    clk_27m = 1'b1;
    @(negedge clk_main_a);
    rst_gen = 1'b0;
    begin
      int nt;
      nt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk_main_a);
        if (tick) nt++;
      end
      n_cmp++;
      if (nt !== 0 || pcr_ext_cnt !== 9'd0) begin
        n_mis++;
        $display("FAIL release_no_tick: got %0d ticks ext %0d exp 0 ticks ext 0", nt, pcr_ext_cnt);
      end
    end
    clk_27m = 1'b0;
    repeat (4) @(negedge clk_main_a);
    m = '0;
    edge_expect("resume_after_reset");
  endtask

  task automatic test_nco();
    logic [32:0] sum;
    logic [31:0] acc_m;
    exp_t        e;
    pcr_val_t    s;
    int          nsnap;
    do_load(33'd0, 9'd0);
    m = '0; acc_m = '0; nsnap = 0;
    src_sel = 1'b1; nco_inc = 32'h8000_0000;
    for (int c = 0; c < 600; c++) begin
      snap_req = (c >= 10 && c < 14);
      if (snap_req) snap_q.push_back(m);
      sum   = {1'b0, acc_m} + {1'b0, nco_inc};
      acc_m = sum[31:0];
      if (sum[32]) m = model_adv(m);
      e.v = m; e.t = sum[32];
      exp_q.push_back(e);
      @(negedge clk_main_a);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pcr_base_cnt, pcr_ext_cnt} !== e.v || tick !== e.t) begin
        n_mis++;
        $display("FAIL nco[%0d]: got %0d/%0d t%0b exp %0d/%0d t%0b", c, pcr_base_cnt, pcr_ext_cnt, tick, e.v.base, e.v.ext, e.t);
      end
      if (snap_valid) begin
        nsnap++;
        if (snap_q.size() != 0) begin
          s = snap_q.pop_front();
          n_cmp++;
          if ({snap_base, snap_ext} !== s) begin
            n_mis++;
            $display("FAIL nco_snap: got %0d/%0d exp %0d/%0d", snap_base, snap_ext, s.base, s.ext);
          end
        end
      end
    end
    snap_req = 1'b0;
    src_sel  = 1'b0;
    n_cmp++;
    if (nsnap !== 4 || snap_q.size() != 0) begin
      n_mis++;
      $display("FAIL back_to_back_snaps: got %0d exp 4", nsnap);
    end
    snap_q.delete();
    n_cmp++;
    if (pcr_base_cnt !== 33'd1 || pcr_ext_cnt !== 9'd0) begin
      n_mis++;
      $display("FAIL nco_600: got %0d/%0d exp 1/0", pcr_base_cnt, pcr_ext_cnt);
    end
  endtask

  task automatic test_loss();
    int got;
    repeat (60) @(negedge clk_main_a);
    n_cmp++;
    if (clk_27m_lost !== 1'b0) begin
      n_mis++;
      $display("FAIL loss_early: got %0b exp 0", clk_27m_lost);
    end
    repeat (10) @(negedge clk_main_a);
    n_cmp++;
    if (clk_27m_lost !== 1'b1) begin
      n_mis++;
      $display("FAIL loss_set: got %0b exp 1", clk_27m_lost);
    end
    src_sel = 1'b1; nco_inc = '0;
    @(negedge clk_main_a);
    src_sel = 1'b0;
    n_cmp++;
    if (clk_27m_lost !== 1'b0) begin
      n_mis++;
      $display("FAIL loss_nco_clear: got %0b exp 0", clk_27m_lost);
    end
    repeat (70) @(negedge clk_main_a);
    n_cmp++;
    if (clk_27m_lost !== 1'b1) begin
      n_mis++;
      $display("FAIL loss_set_again: got %0b exp 1", clk_27m_lost);
    end
    clk_27m = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      @(negedge clk_main_a);
      if (tick) got = 1;
    end
    n_cmp++;
    if (got !== 1) begin
      n_mis++;
      $display("FAIL loss_restart_tick: got none exp tick within 8 cycles");
    end
    @(negedge clk_main_a);
    clk_27m = 1'b0;
    n_cmp++;
    if (clk_27m_lost !== 1'b0 || pcr_base_cnt !== 33'd1 || pcr_ext_cnt !== 9'd1) begin
      n_mis++;
      $display("FAIL loss_clear: got l%0b %0d/%0d exp l0 1/1", clk_27m_lost, pcr_base_cnt, pcr_ext_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ext_wrap();
    test_base_wrap();
    test_load_collision();
    test_snapshot();
    test_async_reset();
    test_nco();
    test_loss();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
